// File: rtl/parallelcnt_sadd_if.sv
// Bitstream bus for parallelcnt_sadd: sampled inputs and registered results.
interface parallelcnt_sadd_if #(
  parameter int NINPUT = 4,
  parameter int WINLEN = 256,
  parameter int CWIDTH = $clog2(NINPUT + 1),
  parameter int TWIDTH = $clog2(WINLEN * NINPUT + 1)
);
  logic              iEn;
  logic              iClr;
  logic [NINPUT-1:0] iA;
  logic [CWIDTH-1:0] oCnt;
  logic              oSum;
  logic [TWIDTH-1:0] oWinTotal;
  logic              oWinDone;

  modport master (
    output iEn, iClr, iA,
    input  oCnt, oSum, oWinTotal, oWinDone
  );

  modport slave (
    input  iEn, iClr, iA,
    output oCnt, oSum, oWinTotal, oWinDone
  );
endinterface

// File: rtl/parallelcnt_sadd.sv
// N-input parallel counter with scaled-add output bitstream and windowed
// ones-total measurement.
module parallelcnt_sadd #(
  parameter int NINPUT = 4,
  parameter int WINLEN = 256,
  parameter int CWIDTH = $clog2(NINPUT + 1),
  parameter int TWIDTH = $clog2(WINLEN * NINPUT + 1)
) (
  input logic          iClk,
  input logic          iRst,
  parallelcnt_sadd_if.slave bus
);

  localparam int WWIDTH = (WINLEN > 1) ? $clog2(WINLEN) : 1;
  localparam int RWIDTH = CWIDTH + 1;
  localparam logic [RWIDTH-1:0] NIN_R  = RWIDTH'(NINPUT);
  localparam logic [WWIDTH-1:0] WLAST  = WWIDTH'(WINLEN - 1);

  logic [CWIDTH-1:0] cnt_q,  cnt_d;
  logic              sum_q,  sum_d;
  logic [TWIDTH-1:0] tot_q,  tot_d;
  logic              done_q, done_d;
  logic [RWIDTH-1:0] res_q,  res_d;
  logic [TWIDTH-1:0] run_q,  run_d;
  logic [WWIDTH-1:0] wcnt_q, wcnt_d;

  logic [CWIDTH-1:0] pcnt;
  logic [RWIDTH-1:0] acc;
  logic [TWIDTH-1:0] run_inc;

  // Popcount of the current input sample.
  always_comb begin
    pcnt = '0;
    for (int unsigned i = 0; i < NINPUT; i++) begin
      pcnt = pcnt + CWIDTH'(bus.iA[i]);
    end
  end

  // Next-state: clear beats enable; idle cycles zero the per-cycle outputs.
  always_comb begin
    cnt_d   = '0;
    sum_d   = 1'b0;
    done_d  = 1'b0;
    tot_d   = tot_q;
    res_d   = res_q;
    run_d   = run_q;
    wcnt_d  = wcnt_q;
    acc     = res_q + RWIDTH'(pcnt);
    run_inc = run_q + TWIDTH'(pcnt);
    if (bus.iClr) begin
      res_d  = '0;
      run_d  = '0;
      wcnt_d = '0;
    end else if (bus.iEn) begin
      cnt_d = pcnt;
      if (acc >= NIN_R) begin
        sum_d = 1'b1;
        res_d = acc - NIN_R;
      end else begin
        res_d = acc;
      end
      if (wcnt_q == WLAST) begin
        tot_d  = run_inc;
        done_d = 1'b1;
        run_d  = '0;
        wcnt_d = '0;
      end else begin
        run_d  = run_inc;
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q  <= '0;
      sum_q  <= 1'b0;
      tot_q  <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
      run_q  <= '0;
      wcnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      tot_q  <= tot_d;
      done_q <= done_d;
      res_q  <= res_d;
      run_q  <= run_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign bus.oCnt      = cnt_q;
  assign bus.oSum      = sum_q;
  assign bus.oWinTotal = tot_q;
  assign bus.oWinDone  = done_q;

endmodule

// File: doc/parallelcnt_sadd.md
# parallelcnt_sadd

Parametrised N-input parallel counter for unary bitstreams. Each enabled cycle it counts the ones across NINPUT input streams and produces a registered count. It also produces a scaled-add output bitstream whose 1-density equals the mean input density (uSADD). A windowed ones-total with a done pulse supports bitstream-length measurement. It sits on the unary datapath wherever several bitstreams are reduced to one.

## Interface
- NINPUT, 4: number of input bitstreams (≥2)
- CWIDTH, $clog2(NINPUT+1): per-cycle count width
- WINLEN, 256: enabled cycles per measurement window (≥1)
- TWIDTH, $clog2(WINLEN*NINPUT+1): window total width
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  synchronous reset, active-high
- iEn  in  1  input-valid; iA sampled only when high
- iClr  in  1  synchronous clear of residual, window counter and running total
- iA  in  NINPUT  one bit per input bitstream
- oCnt  out  CWIDTH  registered popcount of iA
- oSum  out  1  scaled-add output bitstream
- oWinTotal  out  TWIDTH  ones-total of the last completed window
- oWinDone  out  1  one-cycle pulse when oWinTotal updates

## Operation
- Priority: iRst > iClr > iEn.
- Enabled cycle (iEn=1, iClr=0):
  - p = popcount(iA); oCnt <= p.
  - s = res + p, where res is the internal residual, width CWIDTH+1, max 2*NINPUT-1.
  - If s ≥ NINPUT: oSum <= 1 and res <= s−NINPUT. Otherwise oSum <= 0 and res <= s. The residual stays in 0..NINPUT−1.
  - run <= run + p; wcnt <= wcnt + 1.
  - If wcnt == WINLEN−1:
    - oWinTotal <= run + p.
    - oWinDone <= 1.
    - run <= 0; wcnt <= 0 (wrap).
- Idle cycle (iEn=0, iClr=0):
  - oCnt <= 0, oSum <= 0, oWinDone <= 0.
  - res, run and wcnt hold.
  - oWinTotal holds.
- iClr=1:
  - res, run and wcnt <= 0.
  - oCnt, oSum and oWinDone <= 0.
  - oWinTotal holds its last value.
  - iA in that cycle is discarded, even if iEn=1.
- Arithmetic is unsigned. run width is TWIDTH and cannot overflow within one window.
- Long-run ones-count of oSum equals floor(total input ones / NINPUT). The residual carries the fraction.

## Timing
- Reset values: oCnt=0, oSum=0, oWinTotal=0, oWinDone=0. Internal res, run and wcnt are also 0.
- iA sampled at edge t appears on oCnt and oSum after edge t (latency 1 cycle, fully registered outputs).
- oWinDone rises the cycle after the WINLEN-th enabled sample. oWinTotal updates in that same cycle.
- oWinDone is never high for two consecutive cycles unless WINLEN=1.
- With WINLEN=1, oWinDone is high after every enabled cycle.
- iClr in the same cycle as the window-completing sample: the clear wins. No oWinDone is produced and oWinTotal is unchanged.
- Reset mid-window discards the partial window, and oWinTotal returns to 0.
- Gaps in iEn only stretch a window. They never change its contents.

## Test plan
- Reset then single sample (NINPUT=4): hold iRst for 2 cycles, then iEn=1, iA=4'b1011 for one cycle. Required: all outputs 0 during reset; oCnt=3 one cycle later; then oCnt=0 once iEn=0.
- Scaled-add pattern (NINPUT=4): iA=4'b1011 held with iEn=1 for 8 cycles. Required: oSum sequence 0,1,1,1,0,1,1,1 (density 3/4); oCnt=3 throughout.
- Boundary counts (NINPUT=4): iA=0000 for 4 cycles, then 1111 for 4 cycles. Required: oCnt=0 then 4; oSum=0×4 then 1×4; residual stays 0.
- Window (NINPUT=4, WINLEN=8): iA=1111 for 8 enabled cycles, with an iEn=0 gap of 3 cycles after cycle 4. Required: a single oWinDone pulse one cycle after the 8th enabled sample; oWinTotal=32 (6-bit); no pulse during the gap.
- Clear collision (WINLEN=8): assert iClr together with the 8th enabled sample. Required: no oWinDone; oWinTotal keeps its previous value; next window starts from run=0 and oSum restarts from residual 0.
- Mid-run reset: after 5 samples of iA=1011, assert iRst for 1 cycle with iEn=1. Required: all outputs 0 the next cycle; subsequent oSum pattern restarts at 0,1,1,1.
